onehot_encoder: RTL and testbench

//  Inverse of the 3-to-8 one-hot decoder: accepts an N-bit one-hot word and returns its binary index.

---
 rtl/onehot_pkg.sv | 25 ++
 rtl/onehot_enc_core.sv | 49 ++++
 rtl/onehot_encoder.sv | 112 +++++++++++
 tb/tb_onehot_encoder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_pkg.sv
// Shared constants for the one-hot to binary encoder.
//   ONEHOT_N     default one-hot input width
//   ONEHOT_W     default index width, log2 of ONEHOT_N
//   ONEHOT_CNT_W default width of the malformed-word counter
//   clog2()      ceiling log2, for tools that cannot fold $clog2 in parameters
package onehot_pkg;

  // Ceiling log2. A value of 0 or 1 returns 0.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int ONEHOT_N     = 8;
  localparam int ONEHOT_W     = clog2(ONEHOT_N);
  localparam int ONEHOT_CNT_W = 8;

endpackage : onehot_pkg

// File: rtl/onehot_enc_core.sv
// Combinational core of the one-hot encoder.
// It returns the index of the lowest set bit, flags whether any bit is set,
// and flags whether more than one bit is set.
//   word_i   N-bit input word
//   code_o   index of the lowest set bit (0 when no bit is set)
//   any_o    at least one bit is set
//   multi_o  two or more bits are set
module onehot_enc_core
  import onehot_pkg::*;
#(
  parameter int N = ONEHOT_N,
  parameter int W = clog2(ONEHOT_N)
) (
  input  logic [N-1:0] word_i,
  output logic [W-1:0] code_o,
  output logic         any_o,
  output logic         multi_o
);

  // The popcount needs to hold values up to N.
  localparam int PW = clog2(N + 1);

  logic          found;
  logic [PW-1:0] pop;

  // Lowest-set-bit priority search. After the first hit, higher bits are
  // ignored. This makes a multi-bit word report its lowest index.
  always_comb begin
    code_o = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (word_i[i] && !found) begin
        code_o = W'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + PW'(word_i[i]);
    end
  end

  assign any_o   = found;
  assign multi_o = (pop > PW'(1));

endmodule : onehot_enc_core

// File: rtl/onehot_encoder.sv
// Registered one-hot to binary encoder with a valid/ready handshake on both
// sides. It has a single-entry output stage and a saturating counter of
// malformed words.
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   in_onehot is valid this cycle
//   in_ready   block accepts a word this cycle
//   in_onehot  one-hot word; bit i set means index i
//   out_valid  out_code/out_err hold a result
//   out_ready  consumer takes the result this cycle
//   out_code   binary index of the (lowest) set bit
//   out_err    word was all-zero or had more than one bit set
//   err_cnt    count of accepted malformed words; saturates at all-ones
//   err_clr    clears err_cnt; wins over a same-cycle increment
module onehot_encoder
  import onehot_pkg::*;
#(
  parameter int N     = ONEHOT_N,
  parameter int W     = clog2(N),
  parameter int CNT_W = ONEHOT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_onehot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_code,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_code_q,  out_code_d;
  logic             out_err_q,   out_err_d;
  logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;

  logic [N-1:0] word_gated;
  logic [W-1:0] core_code;
  logic         core_any;
  logic         core_multi;
  logic         core_err;
  logic         accept;
  logic         drain;

  // Gate the word with in_valid. An idle or undriven bus then cannot push
  // X values into the encoder.
  assign word_gated = in_valid ? in_onehot : '0;

  onehot_enc_core #(
    .N (N),
    .W (W)
  ) u_core (
    .word_i  (word_gated),
    .code_o  (core_code),
    .any_o   (core_any),
    .multi_o (core_multi)
  );

  assign core_err = !core_any || core_multi;

  // in_ready does not depend on in_valid. A result that drains this cycle
  // frees the slot, so one word per cycle gets through.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_err_d   = out_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_code_d  = core_code;
      out_err_d   = core_err;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear has priority. A malformed word in the same cycle is dropped.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (accept && core_err && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule : onehot_encoder

// File: tb/tb_onehot_encoder.sv
module tb_onehot_encoder;

  localparam int N     = 8;
  localparam int W     = 3;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_onehot;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_code;
  logic             out_err;
  logic [CNT_W-1:0] err_cnt;
  logic             err_clr;

  int checks   = 0;
  int failures = 0;

  onehot_encoder #(
    .N     (N),
    .W     (W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_onehot (in_onehot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_err   (out_err),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock. Inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_onehot = 8'h01;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (out_code !== 3'd0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_code_err got=%0d/%b exp=0/0", out_code, out_err);
    end
  endtask

  task automatic test_sweep();
    logic [N-1:0] w;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w         = 8'h01 << i;
      in_valid  = 1'b1;
      in_onehot = w;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL sweep_in_ready[%0d] got=%b exp=1", i, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_code !== 3'(i) || out_err !== 1'b0) begin
        failures++;
        $display("FAIL sweep_result[%0d] got v=%b code=%0d err=%b exp v=1 code=%0d err=0",
                 i, out_valid, out_code, out_err, i);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sweep_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_malformed();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_onehot = 8'h00;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_code !== 3'd0 || out_err !== 1'b1) begin
      failures++;
      $display("FAIL malformed_zero got v=%b code=%0d err=%b exp v=1 code=0 err=1",
               out_valid, out_code, out_err);
    end
    in_onehot = 8'h28;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_code !== 3'd3 || out_err !== 1'b1) begin
      failures++;
      $display("FAIL malformed_multi got v=%b code=%0d err=%b exp v=1 code=3 err=1",
               out_valid, out_code, out_err);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (err_cnt !== 8'd2) begin
      failures++;
      $display("FAIL malformed_err_cnt got=%0d exp=2", err_cnt);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_onehot = 8'h10;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_code !== 3'd4) begin
      failures++;
      $display("FAIL bp_first got v=%b code=%0d exp v=1 code=4", out_valid, out_code);
    end
    in_onehot = 8'h02;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_code !== 3'd4 || out_err !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got rdy=%b v=%b code=%0d err=%b exp rdy=0 v=1 code=4 err=0",
                 c, in_ready, out_valid, out_code, out_err);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready got=%b exp=1", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_code !== 3'd1 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL bp_second got v=%b code=%0d err=%b exp v=1 code=1 err=0",
               out_valid, out_code, out_err);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_counter();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    err_clr   = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL cnt_clear got=%0d exp=0", err_cnt);
    end
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'b1;
      in_onehot = (i % 2 == 1) ? 8'hFF : 8'h00;
      step();
      if (i == 254) begin
        checks++;
        if (err_cnt !== 8'd255) begin
          failures++;
          $display("FAIL cnt_reach_max got=%0d exp=255", err_cnt);
        end
      end
    end
    checks++;
    if (err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL cnt_saturate got=%0d exp=255", err_cnt);
    end
    in_onehot = 8'h03;
    err_clr   = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL cnt_clr_priority got=%0d exp=0", err_cnt);
    end
    in_onehot = 8'h81;
    step();
    checks++;
    if (err_cnt !== 8'd1 || out_code !== 3'd0 || out_err !== 1'b1) begin
      failures++;
      $display("FAIL cnt_after_clr got cnt=%0d code=%0d err=%b exp cnt=1 code=0 err=1",
               err_cnt, out_code, out_err);
    end
    in_onehot = 8'h40;
    step();
    checks++;
    if (err_cnt !== 8'd1 || out_code !== 3'd6 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL cnt_good_word got cnt=%0d code=%0d err=%b exp cnt=1 code=6 err=0",
               err_cnt, out_code, out_err);
    end
    in_valid  = 1'b0;
    in_onehot = 8'h00;
    step();
    step();
    checks++;
    if (err_cnt !== 8'd1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL cnt_idle_bad_word got cnt=%0d v=%b exp cnt=1 v=0", err_cnt, out_valid);
    end
  endtask

  task automatic test_midop_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_onehot = 8'h08;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_code !== 3'd3) begin
      failures++;
      $display("FAIL midrst_setup got v=%b code=%0d exp v=1 code=3", out_valid, out_code);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_code !== 3'd0 || err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL midrst_cleared got v=%b code=%0d cnt=%0d exp v=0 code=0 cnt=0",
               out_valid, out_code, err_cnt);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_no_replay[%0d] got v=%b exp v=0", c, out_valid);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_onehot = '0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    #1;
    test_reset();
    test_sweep();
    test_malformed();
    test_backpressure();
    test_counter();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_onehot_encoder
